cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 155 +++++++++++++++
 tb/tb_cache_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Cache controller: read lookup with miss fill, write-update/write-through.
// One FSM with registered outputs and saturating hit/miss counters.
module cache_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_done,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   output logic [DATA_WIDTH-1:0] cache_wdata,
   output logic                  cache_we,
   output logic                  cache_re,
   input  logic                  cache_hit,
   input  logic [DATA_WIDTH-1:0] cache_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, MEM_WR, DONE
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Outputs are set for the state being entered, so they are pure flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
         cpu_ready   <= 1'b1;
         cpu_done    <= 1'b0;
         cpu_rdata   <= '0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         cache_we    <= 1'b0;
         cache_re    <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         cpu_ready   <= 1'b0;
         cpu_done    <= 1'b0;
         cpu_rdata   <= '0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         cache_we    <= 1'b0;
         cache_re    <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         unique case (state)
            IDLE: begin
               if (cpu_req) begin
                  addr_q     <= cpu_addr;
                  wdata_q    <= cpu_wdata;
                  cache_addr <= cpu_addr;
                  if (cpu_we) begin
                     state       <= WR_CACHE;
                     cache_we    <= 1'b1;
                     cache_wdata <= cpu_wdata;
                  end else begin
                     state    <= LOOKUP;
                     cache_re <= 1'b1;
                  end
               end else begin
                  cpu_ready <= 1'b1;
               end
            end
            LOOKUP: state <= CHECK;
            CHECK: begin
               if (cache_hit) begin
                  state     <= DONE;
                  data_q    <= cache_rdata;
                  cpu_done  <= 1'b1;
                  cpu_rdata <= cache_rdata;
                  if (hit_count != 16'hFFFF)
                     hit_count <= hit_count + 16'd1;
               end else begin
                  state    <= MEM_RD;
                  mem_req  <= 1'b1;
                  mem_addr <= addr_q;
                  if (miss_count != 16'hFFFF)
                     miss_count <= miss_count + 16'd1;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  state       <= FILL;
                  data_q      <= mem_rdata;
                  cache_we    <= 1'b1;
                  cache_addr  <= addr_q;
                  cache_wdata <= mem_rdata;
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= addr_q;
               end
            end
            FILL: begin
               state     <= DONE;
               cpu_done  <= 1'b1;
               cpu_rdata <= data_q;
            end
            WR_CACHE: begin
               state     <= MEM_WR;
               mem_req   <= 1'b1;
               mem_we    <= 1'b1;
               mem_addr  <= addr_q;
               mem_wdata <= wdata_q;
            end
            MEM_WR: begin
               if (mem_ack) begin
                  state    <= DONE;
                  cpu_done <= 1'b1;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= wdata_q;
               end
            end
            DONE: begin
               state     <= IDLE;
               cpu_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               cpu_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: queue-based transaction model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_cache_ctrl;
   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ready, cpu_done;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] cache_addr;
   logic [DW-1:0] cache_wdata;
   logic          cache_we, cache_re;
   logic          cache_hit = 1'b0;
   logic [DW-1:0] cache_rdata = '0;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [15:0]   hit_count, miss_count;

   cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done),
      .cpu_rdata(cpu_rdata),
      .cache_addr(cache_addr), .cache_wdata(cache_wdata),
      .cache_we(cache_we), .cache_re(cache_re),
      .cache_hit(cache_hit), .cache_rdata(cache_rdata),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic          ready;
      logic          done;
      logic [DW-1:0] rdata;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwdata;
      logic          cwe;
      logic          cre;
      logic          mreq;
      logic          mwe;
      logic [AW-1:0] maddr;
      logic [DW-1:0] mwdata;
   } obs_t;

   typedef enum logic [1:0] {K_NONE, K_CHECK, K_WAIT} kind_t;
   typedef struct packed {
      obs_t  o;
      kind_t k;
   } rec_t;

   // Model: expected outputs for the cycle after each edge
   rec_t          q[$];
   obs_t          cur;
   logic          chk = 1'b0;
   logic          mwait = 1'b0;
   logic          mwr = 1'b0;
   logic [AW-1:0] a = '0;
   logic [DW-1:0] wd = '0;
   logic [15:0]   hits = '0;
   logic [15:0]   misses = '0;
   logic          hit_preset = 1'b0;

   function automatic obs_t idle_o();
      obs_t o = '0;
      o.ready = 1'b1;
      return o;
   endfunction

   function automatic obs_t done_o(input logic [DW-1:0] d);
      obs_t o = '0;
      o.done = 1'b1;
      o.rdata = d;
      return o;
   endfunction

   function automatic obs_t mem_o(input logic w);
      obs_t o = '0;
      o.mreq = 1'b1;
      o.mwe = w;
      o.maddr = a;
      o.mwdata = w ? wd : '0;
      return o;
   endfunction

   task automatic push(input obs_t o, input kind_t k);
      rec_t r;
      r.o = o;
      r.k = k;
      q.push_back(r);
   endtask

   initial begin
      rec_t r;
      cur = idle_o();
      forever begin
         @(posedge clk);
         if (hit_preset) hits = 16'hFFFF;
         if (reset) begin
            q.delete();
            chk = 1'b0;
            mwait = 1'b0;
            hits = '0;
            misses = '0;
            cur = idle_o();
         end else if (chk) begin
            chk = 1'b0;
            if (cache_hit) begin
               if (hits != 16'hFFFF) hits = hits + 16'd1;
               cur = done_o(cache_rdata);
            end else begin
               if (misses != 16'hFFFF) misses = misses + 16'd1;
               cur = mem_o(1'b0);
               mwait = 1'b1;
            end
         end else if (mwait) begin
            if (mem_ack) begin
               mwait = 1'b0;
               if (mwr) begin
                  cur = done_o('0);
               end else begin
                  cur = '0;
                  cur.cwe = 1'b1;
                  cur.caddr = a;
                  cur.cwdata = mem_rdata;
                  push(done_o(mem_rdata), K_NONE);
               end
            end
         end else if (q.size() != 0) begin
            r = q.pop_front();
            cur = r.o;
            chk = (r.k == K_CHECK);
            mwait = (r.k == K_WAIT);
         end else if (cur.ready && cpu_req) begin
            a = cpu_addr;
            wd = cpu_wdata;
            mwr = cpu_we;
            cur = '0;
            cur.caddr = a;
            if (cpu_we) begin
               cur.cwe = 1'b1;
               cur.cwdata = wd;
               push(mem_o(1'b1), K_WAIT);
            end else begin
               cur.cre = 1'b1;
               push('0, K_CHECK);
            end
         end else begin
            cur = idle_o();
         end
      end
   end

   function automatic obs_t dut_obs();
      obs_t o;
      o.ready = cpu_ready;
      o.done = cpu_done;
      o.rdata = cpu_rdata;
      o.caddr = cache_addr;
      o.cwdata = cache_wdata;
      o.cwe = cache_we;
      o.cre = cache_re;
      o.mreq = mem_req;
      o.mwe = mem_we;
      o.maddr = mem_addr;
      o.mwdata = mem_wdata;
      return o;
   endfunction

   bit cmp_en = 0;
   bit cnt_en = 0;

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("outputs", 128'(dut_obs()), 128'(cur));
         if (cache_we && cache_re)
            check("we_re_excl", 128'(1), 128'(0));
         if (cnt_en) begin
            check("hit_count", 128'(hit_count), 128'(hits));
            check("miss_count", 128'(miss_count), 128'(misses));
         end
      end
   end

   // Memory responder and stray-ack source
   bit            resp_en = 0;
   bit            stray = 0;
   int            ack_dly = 0;
   logic [DW-1:0] ack_data = '0;
   int            wcnt = 0;

   initial forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && resp_en) begin
         if (wcnt == ack_dly) begin
            mem_ack = 1'b1;
            mem_rdata = ack_data;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
         if (stray) begin
            mem_ack = 1'b1;
            mem_rdata = 16'hDEAD;
         end
      end
   end

   // Event monitor for literal timing checks
   int            cwe_n = 0, cwe_cyc = 0, mreq_n = 0, mreq_rise = 0;
   int            done_n = 0;
   logic [AW-1:0] cwe_addr = '0;
   logic [DW-1:0] cwe_data = '0;
   logic          mreq_prev = 1'b0, mreq_wel = 1'b0;

   initial forever begin
      @(negedge clk);
      if (cache_we) begin
         cwe_n++;
         cwe_cyc = cyc;
         cwe_addr = cache_addr;
         cwe_data = cache_wdata;
      end
      if (mem_req) begin
         mreq_n++;
         if (!mreq_prev) mreq_rise = cyc;
         mreq_wel = mem_we;
      end
      if (cpu_done) done_n++;
      mreq_prev = mem_req;
   end

   task automatic txn(input logic w, input logic [AW-1:0] ad,
                      input logic [DW-1:0] d, input bit hold,
                      output int t, output int lat,
                      output logic [DW-1:0] rd);
      bit seen = 0;
      cpu_req = 1'b1;
      cpu_we = w;
      cpu_addr = ad;
      cpu_wdata = d;
      t = cyc;
      lat = -1;
      rd = '0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (!hold) cpu_req = 1'b0;
         if (cpu_done) begin
            seen = 1;
            lat = cyc - t;
            rd = cpu_rdata;
            cpu_req = 1'b0;
         end
      end
      if (!seen) check("done_timeout", 128'(0), 128'(1));
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, lat, c0, m0, d0;
      logic [DW-1:0] rd;
      bit seen;

      repeat (2) @(negedge clk);
      check("rst_ready", 128'(cpu_ready), 128'(1));
      check("rst_done", 128'(cpu_done), 128'(0));
      check("rst_mreq", 128'(mem_req), 128'(0));
      check("rst_hits", 128'(hit_count), 128'(0));
      check("rst_miss", 128'(miss_count), 128'(0));
      cmp_en = 1;
      cnt_en = 1;
      reset = 1'b0;
      @(negedge clk);

      // Read hit
      cache_hit = 1'b1;
      cache_rdata = 16'hBEEF;
      m0 = mreq_n;
      txn(1'b0, 10'h012, '0, 0, t, lat, rd);
      check("hit_lat", 128'(lat), 128'(3));
      check("hit_data", 128'(rd), 128'(16'hBEEF));
      check("hit_cnt", 128'(hit_count), 128'(1));
      check("hit_nomem", 128'(mreq_n - m0), 128'(0));

      // Read miss, ack two cycles after request
      cache_hit = 1'b0;
      cache_rdata = 16'h5555;
      resp_en = 1;
      ack_dly = 2;
      ack_data = 16'h1234;
      c0 = cwe_n;
      txn(1'b0, 10'h3FF, '0, 0, t, lat, rd);
      check("miss_lat", 128'(lat), 128'(7));
      check("miss_data", 128'(rd), 128'(16'h1234));
      check("miss_cnt", 128'(miss_count), 128'(1));
      check("fill_n", 128'(cwe_n - c0), 128'(1));
      check("fill_addr", 128'(cwe_addr), 128'(10'h3FF));
      check("fill_data", 128'(cwe_data), 128'(16'h1234));
      check("fill_cyc", 128'(cwe_cyc - t), 128'(6));

      // Write, immediate ack
      ack_dly = 0;
      txn(1'b1, 10'h005, 16'hA5A5, 0, t, lat, rd);
      check("wr_lat", 128'(lat), 128'(3));
      check("wr_cwe_cyc", 128'(cwe_cyc - t), 128'(1));
      check("wr_cwe_data", 128'(cwe_data), 128'(16'hA5A5));
      check("wr_mreq_cyc", 128'(mreq_rise - t), 128'(2));
      check("wr_mwe", 128'(mreq_wel), 128'(1));
      check("wr_rdata", 128'(rd), 128'(0));
      check("wr_hits", 128'(hit_count), 128'(1));
      check("wr_miss", 128'(miss_count), 128'(1));

      // Write with slow ack
      ack_dly = 3;
      txn(1'b1, 10'h2C3, 16'h0F1E, 0, t, lat, rd);
      check("wr3_lat", 128'(lat), 128'(6));

      // Held cpu_req through a miss, stray acks everywhere else
      ack_dly = 1;
      ack_data = 16'h0F0F;
      stray = 1;
      m0 = mreq_n;
      d0 = done_n;
      txn(1'b0, 10'h2A0, '0, 1, t, lat, rd);
      repeat (4) @(negedge clk);
      stray = 0;
      check("hold_lat", 128'(lat), 128'(6));
      check("hold_data", 128'(rd), 128'(16'h0F0F));
      check("hold_miss", 128'(miss_count), 128'(2));
      check("hold_mreq", 128'(mreq_n - m0), 128'(2));
      check("hold_dones", 128'(done_n - d0), 128'(1));

      // Second hit with other data
      cache_hit = 1'b1;
      cache_rdata = 16'h0001;
      txn(1'b0, 10'h155, '0, 0, t, lat, rd);
      check("hit2_data", 128'(rd), 128'(16'h0001));
      check("hit2_cnt", 128'(hit_count), 128'(2));

      // Reset while waiting for a read ack
      cache_hit = 1'b0;
      resp_en = 0;
      d0 = done_n;
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 10'h0AB;
      @(negedge clk);
      cpu_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1;
      end
      check("rst_mrd_reached", 128'(seen), 128'(1));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrd_rst_ready", 128'(cpu_ready), 128'(1));
      check("mrd_rst_mreq", 128'(mem_req), 128'(0));
      check("mrd_rst_hits", 128'(hit_count), 128'(0));
      check("mrd_rst_miss", 128'(miss_count), 128'(0));
      resp_en = 1;
      stray = 1;
      repeat (5) @(negedge clk);
      stray = 0;
      check("mrd_rst_nodone", 128'(done_n - d0), 128'(0));
      check("mrd_rst_idle", 128'(cpu_ready), 128'(1));

      // Hit counter saturation, counter preloaded near the top
      cnt_en = 0;
      force dut.hit_count = 16'hFFFE;
      hit_preset = 1'b1;
      @(negedge clk);
      hit_preset = 1'b0;
      cache_hit = 1'b1;
      cache_rdata = 16'h7777;
      txn(1'b0, 10'h100, '0, 0, t, lat, rd);
      release dut.hit_count;
      txn(1'b0, 10'h101, '0, 0, t, lat, rd);
      cnt_en = 1;
      txn(1'b0, 10'h102, '0, 0, t, lat, rd);
      check("sat_hits", 128'(hit_count), 128'(16'hFFFF));
      check("sat_miss", 128'(miss_count), 128'(0));
      check("sat_data", 128'(rd), 128'(16'h7777));

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
